sha_final_stage: RTL and testbench
==================================

SHA_FINAL_STAGE -- requirements
Module: sha_final_stage

Interface
REQ-001 SHALL have parameter WORD_S, default 32, word width in bits (32 = SHA-256, 64 = SHA-512).
REQ-002 SHALL have parameter NONCE_W, default 32, nonce tag width.
REQ-003 SHALL have parameter CNT_W, default 16, width of hit/drop counters.
REQ-004 SHALL derive local H_SIZE = 8*WORD_S; word k occupies bits [k*WORD_S +: WORD_S].
REQ-005 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have ports in_valid input 1 and in_ready output 1, input handshake.
REQ-008 SHALL have port nonce, input, NONCE_W, tag carried with the block.
REQ-009 SHALL have port H_i, input, H_SIZE, chaining value.
REQ-010 SHALL have port work_i, input, H_SIZE, working variables: word 0=h, 1=g, 2=f, 3=e, 4=d, 5=c, 6=b, 7=a.
REQ-011 SHALL have port target, input, H_SIZE, difficulty threshold; word 7 most significant.
REQ-012 SHALL have port filter_en, input, 1: 1 = forward hits only, 0 = forward all.
REQ-013 SHALL have ports out_valid output 1 and out_ready input 1, output handshake.
REQ-014 SHALL have ports H output H_SIZE (digest), nonce_out output NONCE_W, hit output 1.
REQ-015 SHALL have ports hit_cnt and drop_cnt, output, CNT_W each.

Function
REQ-016 SHALL transfer input when in_valid && in_ready; output when out_valid && out_ready.
REQ-017 SHALL implement two registered stages S1 (sum) and S2 (compare/output), each with a valid flag.
REQ-018 On input transfer, S1 SHALL load word k = H_i word k + work_i word k, modulo 2^WORD_S per word, no inter-word carry; S1 nonce = nonce.
REQ-019 Hit SHALL be computed from the S1 digest as unsigned H_SIZE-bit compare: digest <= target, with word 7 most significant.
REQ-020 target and filter_en SHALL be sampled in the cycle S1 advances to S2.
REQ-021 S1 SHALL advance when S1 valid and (S2 empty or S2 transferring out in that cycle).
REQ-022 On advance with filter_en=0, or filter_en=1 and hit=1: S2 SHALL load digest, nonce, and hit.
REQ-023 On advance with filter_en=1 and hit=0: block SHALL be discarded, S2 not loaded, drop_cnt += 1.
REQ-024 hit_cnt SHALL increment on each advance with hit=1, regardless of filter_en.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1, no wrap.
REQ-026 in_ready SHALL be high when S1 empty or S1 advances (or is discarded) in that cycle; combinational, no dependence on in_valid.
REQ-027 out_valid SHALL equal S2 valid; H, nonce_out, hit SHALL hold stable while out_valid && !out_ready.
REQ-028 Latency SHALL be 2 cycles input transfer to out_valid when unstalled; sustained throughput 1 block/cycle with out_ready=1.
REQ-029 Simultaneous S2 output transfer and S1 advance SHALL reload S2 in same cycle, no bubble.
REQ-030 No block SHALL be lost or duplicated under any out_ready pattern; order preserved.

Reset
REQ-031 While reset=1: S1/S2 valid=0, H=0, nonce_out=0, hit=0, hit_cnt=0, drop_cnt=0; in_ready=0 during reset cycle.
REQ-032 Reset mid-operation SHALL discard all in-flight blocks; first transfer allowed in cycle after reset deasserts.

Verification
REQ-033 WORD_S=32: H_i words=32'hFFFF_FFFF, work_i words=32'h0000_0002, filter_en=0 -> 2 cycles later out_valid=1, every H word=32'h0000_0001.
REQ-034 Target compare: digest word7=0, target word7=0, digest word0=5, target word0=4 -> hit=0; target word0=5 -> hit=1, hit_cnt=1.
REQ-035 filter_en=1, 4 back-to-back blocks, hits on 2nd and 4th only -> exactly 2 outputs with nonces 2,4 in order, drop_cnt=2, hit_cnt=2.
REQ-036 out_ready=0 for 5 cycles, in_valid=1 continuous -> in_ready low after 2 accepted, outputs held stable; release -> all 5 nonces delivered in order, none lost.
REQ-037 WORD_S=64 with CNT_W=2: 5 hits -> hit_cnt saturates at 3; per-word 64-bit wrap verified.
REQ-038 reset asserted with both stages valid -> next cycle out_valid=0, counters 0, no stale output after deassert.

Source files
------------

// File: rtl/sha_final_stage.sv
// Final SHA-2 compression stage: adds the working variables into the chaining value,
// compares the digest against a difficulty target and optionally forwards only hits.
module sha_final_stage #(
    parameter int WORD_S  = 32,
    parameter int NONCE_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NONCE_W-1:0]    nonce,
    input  logic [8*WORD_S-1:0]   H_i,
    input  logic [8*WORD_S-1:0]   work_i,
    input  logic [8*WORD_S-1:0]   target,
    input  logic                  filter_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*WORD_S-1:0]   H,
    output logic [NONCE_W-1:0]    nonce_out,
    output logic                  hit,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int H_SIZE = 8 * WORD_S;

    // Per-word modular add; carries never cross word boundaries.
    function automatic logic [H_SIZE-1:0] word_add(input logic [H_SIZE-1:0] a,
                                                   input logic [H_SIZE-1:0] b);
        logic [H_SIZE-1:0] r;
        r = {H_SIZE{1'b0}};
        for (int k = 0; k < 8; k++) begin
            r[k*WORD_S +: WORD_S] = a[k*WORD_S +: WORD_S] + b[k*WORD_S +: WORD_S];
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [H_SIZE-1:0]    s1_digest_q, s1_digest_d;
    logic [NONCE_W-1:0]   s1_nonce_q, s1_nonce_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [H_SIZE-1:0]    s2_digest_q, s2_digest_d;
    logic [NONCE_W-1:0]   s2_nonce_q, s2_nonce_d;
    logic                 s2_hit_q, s2_hit_d;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

    logic hit_s;
    logic keep_s;
    logic out_xfer_s;
    logic s1_adv_s;
    logic in_ready_s;
    logic in_xfer_s;

    // Handshake decode; word 7 sits in the top bits, so a plain unsigned compare orders correctly.
    always_comb begin
        hit_s      = (s1_digest_q <= target);
        keep_s     = !filter_en || hit_s;
        out_xfer_s = s2_valid_q && out_ready;
        s1_adv_s   = s1_valid_q && (!s2_valid_q || out_xfer_s);
        in_ready_s = !reset && (!s1_valid_q || s1_adv_s);
        in_xfer_s  = in_valid && in_ready_s;
    end

    // Next-state for both pipeline stages and the saturating counters.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_digest_d = s1_digest_q;
        s1_nonce_d  = s1_nonce_q;
        s2_valid_d  = s2_valid_q;
        s2_digest_d = s2_digest_q;
        s2_nonce_d  = s2_nonce_q;
        s2_hit_d    = s2_hit_q;
        hit_cnt_d   = hit_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (reset) begin
            s1_valid_d  = 1'b0;
            s1_digest_d = {H_SIZE{1'b0}};
            s1_nonce_d  = {NONCE_W{1'b0}};
            s2_valid_d  = 1'b0;
            s2_digest_d = {H_SIZE{1'b0}};
            s2_nonce_d  = {NONCE_W{1'b0}};
            s2_hit_d    = 1'b0;
            hit_cnt_d   = {CNT_W{1'b0}};
            drop_cnt_d  = {CNT_W{1'b0}};
        end else begin
            if (out_xfer_s) begin
                s2_valid_d = 1'b0;
            end else begin
                s2_valid_d = s2_valid_q;
            end
            // A new S2 load overrides the drain above, giving back-to-back output without a bubble.
            if (s1_adv_s) begin
                s1_valid_d = 1'b0;
                if (keep_s) begin
                    s2_valid_d  = 1'b1;
                    s2_digest_d = s1_digest_q;
                    s2_nonce_d  = s1_nonce_q;
                    s2_hit_d    = hit_s;
                end else begin
                    drop_cnt_d  = sat_inc(drop_cnt_q);
                end
                if (hit_s) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                end else begin
                    hit_cnt_d = hit_cnt_q;
                end
            end else begin
                s1_valid_d = s1_valid_q;
            end
            if (in_xfer_s) begin
                s1_valid_d  = 1'b1;
                s1_digest_d = word_add(H_i, work_i);
                s1_nonce_d  = nonce;
            end else begin
                s1_nonce_d  = s1_nonce_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        s1_valid_q  <= s1_valid_d;
        s1_digest_q <= s1_digest_d;
        s1_nonce_q  <= s1_nonce_d;
        s2_valid_q  <= s2_valid_d;
        s2_digest_q <= s2_digest_d;
        s2_nonce_q  <= s2_nonce_d;
        s2_hit_q    <= s2_hit_d;
        hit_cnt_q   <= hit_cnt_d;
        drop_cnt_q  <= drop_cnt_d;
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_q;
    assign H         = s2_digest_q;
    assign nonce_out = s2_nonce_q;
    assign hit       = s2_hit_q;
    assign hit_cnt   = hit_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_sha_final_stage.sv
// Directed bench for sha_final_stage: vector table plus backpressure, filter, reset
// and 64-bit saturation sequences.
module tb_sha_final_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid, in_ready, filter_en, out_valid, out_ready, hit;
    logic [31:0]  nonce, nonce_out;
    logic [255:0] H_i, work_i, target, H;
    logic [15:0]  hit_cnt, drop_cnt;

    logic         in_valid64, in_ready64, filter_en64, out_valid64, out_ready64, hit64;
    logic [31:0]  nonce64, nonce_out64;
    logic [511:0] H_i64, work_i64, target64, H64;
    logic [1:0]   hit_cnt64, drop_cnt64;

    sha_final_stage #(.WORD_S(32), .NONCE_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .nonce(nonce), .H_i(H_i), .work_i(work_i), .target(target),
        .filter_en(filter_en), .out_valid(out_valid), .out_ready(out_ready),
        .H(H), .nonce_out(nonce_out), .hit(hit), .hit_cnt(hit_cnt), .drop_cnt(drop_cnt)
    );

    sha_final_stage #(.WORD_S(64), .NONCE_W(32), .CNT_W(2)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .nonce(nonce64), .H_i(H_i64), .work_i(work_i64), .target(target64),
        .filter_en(filter_en64), .out_valid(out_valid64), .out_ready(out_ready64),
        .H(H64), .nonce_out(nonce_out64), .hit(hit64), .hit_cnt(hit_cnt64), .drop_cnt(drop_cnt64)
    );

    typedef struct {
        logic [255:0] h_i;
        logic [255:0] work;
        logic [255:0] tgt;
        logic         fe;
        logic [255:0] exp_h;
        logic         exp_hit;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitor: records every block that transfers out at the next rising edge.
    logic        collect_en = 1'b0;
    logic [31:0] got_nonce[$];
    logic [31:0] got_w0[$];
    always @(negedge clk) begin
        #1;
        if (collect_en && out_valid && out_ready) begin
            got_nonce.push_back(nonce_out);
            got_w0.push_back(H[31:0]);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        @(negedge clk);
        H_i       = vecs[idx].h_i;
        work_i    = vecs[idx].work;
        target    = vecs[idx].tgt;
        filter_en = vecs[idx].fe;
        nonce     = 32'(idx + 100);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check($sformatf("vec%0d in_ready", idx), in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("vec%0d out_valid early", idx), out_valid, 1'b0);
        @(negedge clk);
        check($sformatf("vec%0d out_valid", idx), out_valid, 1'b1);
        check($sformatf("vec%0d H", idx), H, vecs[idx].exp_h);
        check($sformatf("vec%0d hit", idx), hit, vecs[idx].exp_hit);
        check($sformatf("vec%0d nonce_out", idx), nonce_out, 32'(idx + 100));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int next_n;
        int acc;
        int guard;
        int w0s[4];

        vecs[0] = '{h_i: {8{32'hFFFF_FFFF}}, work: {8{32'h0000_0002}}, tgt: 256'd0, fe: 1'b0,
                    exp_h: {8{32'h0000_0001}}, exp_hit: 1'b0};
        vecs[1] = '{h_i: 256'd2, work: 256'd3, tgt: 256'd4, fe: 1'b0,
                    exp_h: 256'd5, exp_hit: 1'b0};
        vecs[2] = '{h_i: 256'd2, work: 256'd3, tgt: 256'd5, fe: 1'b0,
                    exp_h: 256'd5, exp_hit: 1'b1};
        vecs[3] = '{h_i: 256'h0000_0000_FFFF_FFFF, work: 256'd1, tgt: 256'd0, fe: 1'b0,
                    exp_h: 256'd0, exp_hit: 1'b1};
        vecs[4] = '{h_i: {32'h1, 224'h0}, work: 256'd0, tgt: {32'h0, {7{32'hFFFF_FFFF}}}, fe: 1'b0,
                    exp_h: {32'h1, 224'h0}, exp_hit: 1'b0};
        vecs[5] = '{h_i: 256'd4, work: 256'd5, tgt: {32'h1, 224'h0}, fe: 1'b1,
                    exp_h: 256'd9, exp_hit: 1'b1};
        vecs[6] = '{h_i: {32'h7FFF_FFFF, 64'h0, 32'h8000_0000, 96'h0, 32'hDEAD_BEEF},
                    work: {32'h0000_0001, 64'h0, 32'h8000_0001, 96'h0, 32'h2152_4111},
                    tgt: {8{32'hFFFF_FFFF}}, fe: 1'b0,
                    exp_h: {32'h8000_0000, 64'h0, 32'h0000_0001, 96'h0, 32'h0}, exp_hit: 1'b1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; filter_en = 1'b0;
        nonce = 32'd0; H_i = 256'd0; work_i = 256'd0; target = 256'd0;
        in_valid64 = 1'b0; out_ready64 = 1'b1; filter_en64 = 1'b0; nonce64 = 32'd0;
        H_i64 = 512'd0; work_i64 = 512'd0; target64 = {8{64'hFFFF_FFFF_FFFF_FFFF}};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst out_valid", out_valid, 1'b0);
        check("rst H", H, 256'd0);
        check("rst nonce_out", nonce_out, 32'd0);
        check("rst hit", hit, 1'b0);
        check("rst hit_cnt", hit_cnt, 16'd0);
        check("rst drop_cnt", drop_cnt, 16'd0);
        check("rst in_ready", in_ready, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i);
        @(negedge clk);
        check("table hit_cnt", hit_cnt, 16'd4);
        check("table drop_cnt", drop_cnt, 16'd0);

        // Filter: four back-to-back blocks, hits only on nonces 2 and 4
        do_reset();
        got_nonce.delete(); got_w0.delete();
        collect_en = 1'b1; filter_en = 1'b1; out_ready = 1'b1;
        H_i = 256'd0; target = 256'd5;
        w0s = '{10, 3, 20, 5};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nonce    = 32'(i + 1);
            work_i   = 256'(w0s[i]);
            in_valid = 1'b1;
            #1 check($sformatf("filt in_ready %0d", i), in_ready, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("filt out count", 32'(got_nonce.size()), 32'd2);
        if (got_nonce.size() == 2) begin
            check("filt nonce0", got_nonce[0], 32'd2);
            check("filt nonce1", got_nonce[1], 32'd4);
            check("filt w0 0", got_w0[0], 32'd3);
            check("filt w0 1", got_w0[1], 32'd5);
        end
        check("filt drop_cnt", drop_cnt, 16'd2);
        check("filt hit_cnt", hit_cnt, 16'd2);
        collect_en = 1'b0;

        // Backpressure: out_ready low for 5 cycles with continuous input
        do_reset();
        got_nonce.delete(); got_w0.delete();
        filter_en = 1'b0; target = {8{32'hFFFF_FFFF}}; H_i = 256'd0; out_ready = 1'b0;
        next_n = 1; acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nonce = 32'(next_n); work_i = 256'(next_n); in_valid = 1'b1;
            #1;
            if (c >= 2) begin
                check($sformatf("stall out_valid c%0d", c), out_valid, 1'b1);
                check($sformatf("stall nonce_out c%0d", c), nonce_out, 32'd1);
                check($sformatf("stall H c%0d", c), H, 256'd1);
            end
            if (in_ready) begin
                acc++; next_n++;
            end
        end
        check("stall accepted", 32'(acc), 32'd2);
        check("stall in_ready", in_ready, 1'b0);
        guard = 0;
        while (acc < 5 && guard < 40) begin
            @(negedge clk);
            out_ready = 1'b1; collect_en = 1'b1;
            nonce = 32'(next_n); work_i = 256'(next_n); in_valid = 1'b1;
            #1;
            if (in_ready) begin
                acc++; next_n++;
            end
            guard++;
        end
        check("bp accepted", 32'(acc), 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("bp out count", 32'(got_nonce.size()), 32'd5);
        for (int i = 0; i < got_nonce.size(); i++) begin
            check($sformatf("bp nonce %0d", i), got_nonce[i], 32'(i + 1));
            check($sformatf("bp w0 %0d", i), got_w0[i], 32'(i + 1));
        end
        collect_en = 1'b0;

        // Reset with both stages occupied
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nonce = 32'(20 + i); work_i = 256'(20 + i); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("pre-rst out_valid", out_valid, 1'b1);
        check("pre-rst in_ready", in_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst H", H, 256'd0);
        check("midrst nonce_out", nonce_out, 32'd0);
        check("midrst hit", hit, 1'b0);
        check("midrst hit_cnt", hit_cnt, 16'd0);
        check("midrst drop_cnt", drop_cnt, 16'd0);
        check("midrst in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1 check("postrst in_ready", in_ready, 1'b1);
        got_nonce.delete(); got_w0.delete();
        collect_en = 1'b1; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("postrst stale outputs", 32'(got_nonce.size()), 32'd0);
        collect_en = 1'b0;

        // 64-bit words, 2-bit counters: five hits saturate at 3
        check("w64 hit_cnt start", hit_cnt64, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            H_i64 = {8{64'hFFFF_FFFF_FFFF_FFFF}}; work_i64 = {8{64'h3}};
            nonce64 = 32'(i + 1); in_valid64 = 1'b1;
            #1 check($sformatf("w64 in_ready %0d", i), in_ready64, 1'b1);
        end
        @(negedge clk);
        in_valid64 = 1'b0;
        @(negedge clk);
        check("w64 last out_valid", out_valid64, 1'b1);
        check("w64 H wrap", H64, {8{64'h2}});
        check("w64 nonce_out", nonce_out64, 32'd5);
        repeat (3) @(negedge clk);
        check("w64 hit_cnt sat", hit_cnt64, 2'd3);
        check("w64 drop_cnt", drop_cnt64, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
